// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states (GAP exists only with UART_ARB_GAP_EN)
//   WD_MULT     : watchdog limit expressed in UART bit times (cpb units)
//   MAX_NUM_REQ : largest supported requester count
// Optional feature macro: UART_ARB_GAP_EN (adds the inter-frame GAP state).
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  // A 10-bit frame is 10 bit times; 12 leaves margin before declaring a hang.
  localparam int WD_MULT     = 12;
  localparam int MIN_NUM_REQ = 2;
  localparam int MAX_NUM_REQ = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
`ifdef UART_ARB_GAP_EN
    ,
    GAP       = 2'd3
`endif
  } arb_state_e;

  // Watchdog expiry point in clock cycles for a given clocks-per-bit.
  function automatic int wd_limit(input int clks_per_bit);
    return WD_MULT * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and transmitter-side signals of the arbiter.
//   req_valid [NUM_REQ]   : requester i has a byte pending
//   req_data  [NUM_REQ*8] : requester i's byte on bits [8i+7:8i]
//   req_ready [NUM_REQ]   : one-cycle accept pulse back to requester i
//   tx_dv                 : one-cycle start strobe to the UART transmitter
//   tx_data   [8]         : byte presented to the transmitter
//   tx_active             : transmitter busy flag
//   tx_done               : transmitter end-of-frame pulse
// Modports: slave = arbiter side, master = requesters + transmitter side.
//
// Handshake: a requester raises req_valid with req_data and holds both until
// it sees req_ready for its bit; req_ready is a single-cycle pulse on the
// clock edge where the byte is taken, and the same edge raises tx_dv for one
// cycle. Dropping req_valid before req_ready withdraws the byte silently.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_dv;
  logic [7:0]           tx_data;
  logic                 tx_active;
  logic                 tx_done;

  modport slave (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, tx_dv, tx_data
  );

  modport master (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, tx_dv, tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant selection.
//   req_i [NUM_REQ] : request vector
//   ptr_i [IDX_W]   : index of the previous grant; search starts at ptr_i+1
//   gnt_o [NUM_REQ] : one-hot grant (all zero when nothing is requested)
//   idx_o [IDX_W]   : index of the granted requester
//   any_o           : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting one past the pointer and wrapping; the
  // pointer itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte requesters. A round-robin
// arbiter picks a pending requester whenever the transmitter is idle, the byte
// is registered onto tx_data and a one-cycle tx_dv strobe starts the frame.
// A watchdog returns the FSM to IDLE if tx_done never arrives.
//
// Parameters: NUM_REQ (2..8), cpb (clocks per UART bit, match the transmitter)
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : uart_tx_arbiter_if.slave (requester + transmitter signals)
//   grant_id    : index of the most recent grant
//   busy        : FSM is not IDLE
//   timeout_err : one-cycle pulse when the watchdog expires
//   state_o     : current FSM state, for observation
// Optional feature macro: UART_ARB_GAP_EN -- after tx_done, hold cpb idle
// cycles in GAP (busy high) before returning to IDLE.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int cpb     = 217,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]  grant_id,
  output logic              busy,
  output logic              timeout_err,
  output arb_state_e        state_o
);

  localparam int WD_LIMIT = wd_limit(cpb);
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  arb_state_e         state_q, state_d;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               tout_q, tout_d;
  logic [WD_W-1:0]    wd_q, wd_d;

`ifdef UART_ARB_GAP_EN
  localparam int GAP_W = (cpb > 1) ? $clog2(cpb) : 1;
  logic [GAP_W-1:0]   gap_q, gap_d;
`endif

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    ready_d   = '0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tout_d    = 1'b0;
    wd_d      = wd_q;
`ifdef UART_ARB_GAP_EN
    gap_d     = gap_q;
`endif

    case (state_q)
      IDLE: begin
        if (rr_any && !bus.tx_active) begin
          state_d   = START;
          tx_dv_d   = 1'b1;
          ready_d   = rr_gnt;
          tx_data_d = bus.req_data[{rr_idx, 3'b000} +: 8];
          grant_d   = rr_idx;
          ptr_d     = rr_idx;
          wd_d      = '0;
        end
      end

      START: begin
        // The watchdog counts from the strobe cycle so that expiry lands
        // exactly WD_LIMIT cycles after tx_dv.
        state_d = WAIT_DONE;
        wd_d    = wd_q + 1'b1;
      end

      WAIT_DONE: begin
        // tx_done wins over a simultaneous watchdog expiry.
        if (bus.tx_done) begin
`ifdef UART_ARB_GAP_EN
          state_d = GAP;
          gap_d   = '0;
`else
          state_d = IDLE;
`endif
        end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

`ifdef UART_ARB_GAP_EN
      GAP: begin
        if (gap_q == GAP_W'(cpb - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any frame in flight; the pointer restarts so that
  // requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_dv_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ready_q   <= '0;
      grant_q   <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      tout_q    <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tout_q    <= tout_d;
      wd_q      <= wd_d;
    end
  end

`ifdef UART_ARB_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign bus.tx_dv     = tx_dv_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.req_ready = ready_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = tout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, cpb=217). A behavioural
// transmitter answers each tx_dv with FRAME busy cycles and a tx_done pulse,
// recording every byte it accepts. Honours UART_ARB_GAP_EN for expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int CPB   = 217;
  localparam int FRAME = 20;
  localparam int LIMIT = WD_MULT * CPB;
`ifdef UART_ARB_GAP_EN
  localparam int SPACE = FRAME + 2 + CPB;
`else
  localparam int SPACE = FRAME + 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;
  arb_state_e state_o;

  uart_tx_arbiter #(.NUM_REQ(4), .cpb(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_o     (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- transmitter model ----------------
  bit model_en = 1'b1;
  bit m_busy   = 1'b0;
  int m_cnt    = 0;

  initial forever begin
    @(negedge clk);
    if (model_en) begin
      bus.tx_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.tx_active = 1'b0;
          bus.tx_done   = 1'b1;
          m_busy        = 1'b0;
        end
      end else if (bus.tx_dv && rst_n) begin
        sent_q.push_back(bus.tx_data);
        bus.tx_active = 1'b1;
        m_cnt         = FRAME;
        m_busy        = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the number of negedges until tx_dv is seen, or -1.
  task automatic wait_dv(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (bus.tx_dv) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b expected 0", bus.tx_dv); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", state_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc;
    @(negedge clk);
    bus.req_data[7:0] = 8'h69;
    bus.req_valid     = 4'b0001;
    wait_dv(4, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL single_latency: got %0d cycles expected 1", cyc); end
    checks++; if (bus.tx_data !== 8'h69) begin errors++; $display("FAIL single_tx_data: got %h expected 69", bus.tx_data); end
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready: got %b expected 0001", bus.req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
    checks++; if (state_o !== START || busy !== 1'b1) begin errors++; $display("FAIL single_start: got state %0d busy %b expected START busy 1", state_o, busy); end
    exp_q.push_back(8'h69);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (bus.tx_dv !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got dv %b ready %b expected 0 0000", bus.tx_dv, bus.req_ready); end
    checks++; if (state_o !== WAIT_DONE) begin errors++; $display("FAIL single_wait_state: got %0d expected WAIT_DONE", state_o); end
    wait_idle(1000, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL single_idle: busy still %b after bound, expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] exp_rdy;
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    @(negedge clk);
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_dv(1000, cyc);
      if (k == 0) begin
        checks++; if (cyc != 1) begin errors++; $display("FAIL rr_first_latency: got %0d expected 1", cyc); end
      end else begin
        checks++; if (cyc != SPACE) begin errors++; $display("FAIL rr_spacing_%0d: got %0d cycles expected %0d", k, cyc, SPACE); end
      end
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", k, grant_id, k % 4); end
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready_%0d: got %b expected %b", k, bus.req_ready, exp_rdy); end
      checks++; if (bus.tx_data !== bytes[k % 4]) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, bus.tx_data, bytes[k % 4]); end
      exp_q.push_back(bytes[k % 4]);
      if (k == 4) bus.req_valid = 4'b0000;
    end
    wait_idle(1000, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL rr_idle: busy still %b after bound, expected 0", busy); end
  endtask

  task automatic test_rr_skip();
    int cyc;
    logic [3:0] vecs [4];
    logic [1:0] gexp [4];
    logic [7:0] dexp [4];
    // Last grant was 0: 0100 -> 2, then 0101 -> 0 (not 2), 1000 -> 3, 0011 -> 0 (wrap).
    vecs[0] = 4'b0100; gexp[0] = 2'd2; dexp[0] = 8'h33;
    vecs[1] = 4'b0101; gexp[1] = 2'd0; dexp[1] = 8'h11;
    vecs[2] = 4'b1000; gexp[2] = 2'd3; dexp[2] = 8'h44;
    vecs[3] = 4'b0011; gexp[3] = 2'd0; dexp[3] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = vecs[k];
      wait_dv(10, cyc);
      checks++; if (cyc != 1 || grant_id !== gexp[k]) begin errors++; $display("FAIL skip_grant_%0d: got grant %0d after %0d cycles expected %0d after 1", k, grant_id, cyc, gexp[k]); end
      checks++; if (bus.tx_data !== dexp[k]) begin errors++; $display("FAIL skip_data_%0d: got %h expected %h", k, bus.tx_data, dexp[k]); end
      exp_q.push_back(dexp[k]);
      bus.req_valid = 4'b0000;
      wait_idle(1000, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL skip_idle_%0d: busy still %b, expected 0", k, busy); end
    end
  endtask

  task automatic test_blocked();
    int dv_cnt;
    int cyc;
    @(negedge clk);
    model_en      = 1'b0;
    bus.tx_active = 1'b1;
    bus.tx_done   = 1'b0;
    bus.req_valid = 4'b0010;
    dv_cnt = 0;
    repeat (6) begin @(negedge clk); if (bus.tx_dv || bus.req_ready != 4'b0000) dv_cnt++; end
    checks++; if (dv_cnt != 0 || state_o !== IDLE) begin errors++; $display("FAIL blocked_active: got %0d grants state %0d expected 0 IDLE", dv_cnt, state_o); end
    // Withdrawn before any grant: nothing may come out.
    bus.req_valid = 4'b0000;
    bus.tx_active = 1'b0;
    dv_cnt = 0;
    repeat (6) begin @(negedge clk); if (bus.tx_dv || bus.req_ready != 4'b0000) dv_cnt++; end
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL blocked_withdrawn: got %0d grants expected 0", dv_cnt); end
    // Grant follows one cycle after tx_active falls.
    bus.tx_active = 1'b1;
    bus.req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    model_en      = 1'b1;
    bus.tx_active = 1'b0;
    wait_dv(10, cyc);
    checks++; if (cyc != 1 || grant_id !== 2'd1) begin errors++; $display("FAIL blocked_release: got grant %0d after %0d cycles expected 1 after 1", grant_id, cyc); end
    exp_q.push_back(8'h22);
    bus.req_valid = 4'b0000;
    wait_idle(1000, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL blocked_idle: busy still %b, expected 0", busy); end
  endtask

  task automatic test_timeout();
    int cyc;
    int hit;
    @(negedge clk);
    model_en          = 1'b0;
    bus.tx_active     = 1'b0;
    bus.tx_done       = 1'b0;
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid     = 4'b0001;
    wait_dv(10, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL tout_grant: got %0d cycles expected 1", cyc); end
    bus.req_valid = 4'b0000;
    hit = -1;
    for (int i = 1; i <= LIMIT + 20; i++) begin
      @(negedge clk);
      if (timeout_err) begin hit = i; break; end
    end
    checks++; if (hit != LIMIT) begin errors++; $display("FAIL tout_cycle: got %0d cycles expected %0d", hit, LIMIT); end
    checks++; if (state_o !== IDLE || busy !== 1'b0) begin errors++; $display("FAIL tout_state: got %0d busy %b expected IDLE 0", state_o, busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tout_pulse: got %b expected 0", timeout_err); end
  endtask

  task automatic test_done_at_expiry();
    int cyc;
    int seen;
    @(negedge clk);
    bus.req_data[7:0] = 8'h5C;
    bus.req_valid     = 4'b0001;
    wait_dv(10, cyc);
    checks++; if (cyc != 1 || bus.tx_data !== 8'h5C) begin errors++; $display("FAIL tie_grant: got %h after %0d cycles expected 5c after 1", bus.tx_data, cyc); end
    bus.req_valid = 4'b0000;
    seen = 0;
    repeat (LIMIT - 1) begin @(negedge clk); if (timeout_err) seen++; end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    if (timeout_err) seen++;
    checks++; if (seen != 0) begin errors++; $display("FAIL tie_no_timeout: got %0d pulses expected 0", seen); end
`ifdef UART_ARB_GAP_EN
    checks++; if (state_o !== GAP) begin errors++; $display("FAIL tie_state: got %0d expected GAP", state_o); end
`else
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL tie_state: got %0d expected IDLE", state_o); end
`endif
    wait_idle(1000, cyc);
    checks++; if (cyc < 0 || timeout_err !== 1'b0) begin errors++; $display("FAIL tie_idle: busy %b timeout %b expected 0 0", busy, timeout_err); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    int cnt;
    @(negedge clk);
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = 4'b0100;
    wait_dv(10, cyc);
    checks++; if (cyc != 1 || grant_id !== 2'd2) begin errors++; $display("FAIL rst_pre_grant: got %0d after %0d cycles expected 2 after 1", grant_id, cyc); end
    exp_q.push_back(8'h33);
    bus.req_valid = 4'b0000;
    repeat (5) @(negedge clk);
    checks++; if (state_o !== WAIT_DONE) begin errors++; $display("FAIL rst_pre_state: got %0d expected WAIT_DONE", state_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_dv !== 1'b0 || bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_async_bus: got dv %b data %h ready %b expected 0 00 0000", bus.tx_dv, bus.tx_data, bus.req_ready); end
    checks++; if (grant_id !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0 || state_o !== IDLE) begin errors++; $display("FAIL rst_async_ctl: got grant %0d busy %b tout %b state %0d expected 0 0 0 IDLE", grant_id, busy, timeout_err, state_o); end
    m_busy        = 1'b0;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (bus.tx_dv || bus.req_ready != 4'b0000) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL rst_no_reissue: got %0d grants expected 0", cnt); end
    // 1001 would pick 3 from the old pointer; after reset it must pick 0.
    bus.req_valid = 4'b1001;
    wait_dv(10, cyc);
    checks++; if (cyc != 1 || grant_id !== 2'd0 || bus.tx_data !== 8'h11) begin errors++; $display("FAIL rst_first_grant: got %0d data %h after %0d expected 0 11 after 1", grant_id, bus.tx_data, cyc); end
    exp_q.push_back(8'h11);
    bus.req_valid = 4'b0000;
    wait_idle(1000, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL rst_idle: busy still %b, expected 0", busy); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    logic [7:0] e;
    logic [7:0] s;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;

    test_reset();
    test_single();
    apply_reset();
    test_round_robin();
    test_rr_skip();
    test_blocked();
    test_timeout();
    test_done_at_expiry();
    test_reset_mid_frame();

    checks++;
    if (sent_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sb_count: got %0d bytes expected %0d", sent_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && sent_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sent_q.pop_front();
      checks++;
      if (s !== e) begin
        errors++;
        $display("FAIL sb_byte: got %h expected %h", s, e);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
